multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum wait cycles for a memory handshake before trap.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port instr, input, 32, meaning the instruction word from the instruction register: funct7 [31:25], funct3 [14:12], opcode [6:0].
REQ-005 SHALL have the following ports:
- imem_ready, dmem_ready: inputs, 1 bit each, memory response strobes.
- alu_zero: input, 1 bit, ALU zero flag.
REQ-006 SHALL have the following ports:
- imem_req, dmem_req: outputs, 1 bit each, memory request levels.
- dmem_we: output, 1 bit, data write enable.
REQ-007 SHALL have the following ports:
- pc_we, ir_we: outputs, 1 bit each, one-cycle write strobes for PC and instruction register.
- pc_src: output, 2 bits: 00 = PC+4, 01 = PC+imm, 10 = ALU result.
REQ-008 SHALL have the following ports:
- RegWrite, MemToReg, ALUSrc, immControl: outputs, 1 bit each.
- ALUControl: output, 3 bits.
- All have the meanings already used by the codebase control unit.
REQ-009 SHALL have the following ports:
- trap: output, 1 bit, sticky fault flag.
- state: output, 3 bits, current state for debug.

Function
REQ-010 SHALL implement the following states:
- FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Every unlisted state code SHALL go to TRAP.
REQ-011 FETCH SHALL hold imem_req=1 until imem_ready=1.
- In that cycle it SHALL pulse ir_we=1 and move to DECODE.
- imem_req SHALL drop the next cycle.
REQ-012 DECODE SHALL last exactly one cycle and move to EXEC for a supported opcode; otherwise it SHALL go to TRAP.
- Supported opcodes: 0110011, 0010011, 0001011, 1100011, 0000011, 0100011, 0110111, 1101111, 1100111.
REQ-013 EXEC SHALL drive ALUControl, ALUSrc and immControl.
- Values: ADD 000/0/0, SUB 001/0/0, SLT 100/0/0, AND 011/0/0, ADDI 000/1/1, ADDUQB 010/0/0, BEQ 001/0/1, LW/SW 000/1/1, LUI 101/1/1, JAL 000/0/1, JALR 000/1/1.
- R-type with unsupported funct3/funct7 SHALL go to TRAP.
REQ-014 EXEC next state:
- LW and SW go to MEM.
- BEQ goes to FETCH with pc_we=1; pc_src=01 if alu_zero=1, else 00.
- All other opcodes go to WB.
REQ-015 MEM SHALL hold dmem_req=1 (dmem_we=1 for SW) until dmem_ready=1.
- SW then goes to FETCH with pc_we=1, pc_src=00.
- LW goes to WB.
REQ-016 WB SHALL pulse RegWrite=1 and pc_we=1 for one cycle, then go to FETCH.
- MemToReg=1 for LW only.
- pc_src=01 for JAL, 10 for JALR, 00 otherwise.
REQ-017 A wait counter SHALL count the cycles spent waiting in FETCH or MEM.
- It SHALL clear on state entry.
- If the wait reaches MEM_TIMEOUT cycles without ready, the block SHALL go to TRAP, deasserting the request.
REQ-018 A ready strobe arriving in the same cycle as the timeout SHALL win: the transfer completes with no trap.
REQ-019 In TRAP all strobes and requests SHALL be 0 and trap=1; only reset exits TRAP.
REQ-020 Outputs not named for the current state SHALL be 0.
- pc_we, ir_we and RegWrite SHALL never assert for more than one consecutive cycle.

Reset
REQ-021 While reset=1 the block SHALL enter FETCH, with the wait counter at 0, trap at 0, and every output at 0.
REQ-022 The first imem_req SHALL assert in the first cycle after reset falls.
REQ-023 Reset asserted mid-MEM SHALL drop dmem_req and dmem_we at the next edge, with no RegWrite or pc_we.

Structure
REQ-024 A shared package SHALL hold the state encoding, opcode constants and ALUControl codes, reused by the single-cycle control unit.
REQ-025 The opcode/funct decode SHALL be one combinational sub-module, multicycle_decode, which yields ALU fields, the instruction class and a legal flag.

Verification
REQ-026 ADDI (0x00500093) with imem_ready one cycle after the request SHALL produce:
- ir_we at cycle 1.
- ALUControl=000 and ALUSrc=1 in EXEC.
- RegWrite=1 and pc_we=1 (pc_src=00) at cycle 4.
REQ-027 LW with dmem_ready delayed 3 cycles SHALL:
- hold dmem_req for 4 cycles with dmem_we=0;
- then reach WB with MemToReg=1 and RegWrite=1.
REQ-028 BEQ SHALL yield pc_src=01 with pc_we=1 when alu_zero=1, and pc_src=00 when alu_zero=0, with no RegWrite.
REQ-029 With imem_ready held 0, trap SHALL assert after exactly 15 wait cycles and stay at 1 until reset.
REQ-030 Opcode 0000000 SHALL send DECODE to TRAP.
REQ-031 A reset pulse during an SW MEM wait SHALL:
- clear dmem_req next cycle;
- leave no pc_we;
- restart in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared state encoding, opcodes and ALU codes for the control units
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_t;

   // Coarse instruction class; plain ALU ops (R, ADDI, ADDUQB, LUI) share one write-back path
   typedef enum logic [2:0] {
      IC_ALU  = 3'd0,
      IC_BEQ  = 3'd1,
      IC_LW   = 3'd2,
      IC_SW   = 3'd3,
      IC_JAL  = 3'd4,
      IC_JALR = 3'd5,
      IC_NONE = 3'd7
   } iclass_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_ADDUQB = 7'b0001011;
   localparam logic [6:0] OP_BEQ    = 7'b1100011;
   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_ADDUQB = 3'b010;
   localparam logic [2:0] ALU_AND    = 3'b011;
   localparam logic [2:0] ALU_SLT    = 3'b100;
   localparam logic [2:0] ALU_LUI    = 3'b101;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_ALU   = 2'b10;

endpackage

// File: rtl/multicycle_decode.sv
// rtl/multicycle_decode.sv - combinational opcode/funct decode into ALU fields, class and legality
module multicycle_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  alu_control,
   output logic        alu_src,
   output logic        imm_control,
   output iclass_t     iclass,
   output logic        opcode_ok,
   output logic        legal
);

   logic [6:0] opcode;
   logic [9:0] funct;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct         = {instr[31:25], instr[14:12]};
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   always_comb begin
      alu_control = ALU_ADD;
      alu_src     = 1'b0;
      imm_control = 1'b0;
      iclass      = IC_ALU;
      opcode_ok   = 1'b1;
      legal       = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               10'b0000000_000: alu_control = ALU_ADD;
               10'b0100000_000: alu_control = ALU_SUB;
               10'b0000000_010: alu_control = ALU_SLT;
               10'b0000000_111: alu_control = ALU_AND;
               default:         legal       = 1'b0;
            endcase
         end
         OP_ADDI:   begin alu_src = 1'b1; imm_control = 1'b1; end
         OP_ADDUQB: alu_control = ALU_ADDUQB;
         OP_BEQ:    begin alu_control = ALU_SUB; imm_control = 1'b1; iclass = IC_BEQ; end
         OP_LW:     begin alu_src = 1'b1; imm_control = 1'b1; iclass = IC_LW; end
         OP_SW:     begin alu_src = 1'b1; imm_control = 1'b1; iclass = IC_SW; end
         OP_LUI:    begin alu_control = ALU_LUI; alu_src = 1'b1; imm_control = 1'b1; end
         OP_JAL:    begin imm_control = 1'b1; iclass = IC_JAL; end
         OP_JALR:   begin alu_src = 1'b1; imm_control = 1'b1; iclass = IC_JALR; end
         default: begin
            opcode_ok = 1'b0;
            legal     = 1'b0;
            iclass    = IC_NONE;
         end
      endcase
      if (!legal) begin
         alu_control = ALU_ADD;
         alu_src     = 1'b0;
         imm_control = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM with memory handshake timeout and sticky trap
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        alu_zero,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        pc_we,
   output logic        ir_we,
   output logic [1:0]  pc_src,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        ALUSrc,
   output logic        immControl,
   output logic [2:0]  ALUControl,
   output logic        trap,
   output logic [2:0]  state
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt;
   logic          wait_done;
   logic [2:0]    dec_alu_control;
   logic          dec_alu_src, dec_imm_control, dec_opcode_ok, dec_legal;
   iclass_t       dec_iclass;

   multicycle_decode u_decode (
      .instr       (instr),
      .alu_control (dec_alu_control),
      .alu_src     (dec_alu_src),
      .imm_control (dec_imm_control),
      .iclass      (dec_iclass),
      .opcode_ok   (dec_opcode_ok),
      .legal       (dec_legal)
   );

   // wait_cnt holds the number of earlier wait cycles spent in the current state
   assign wait_done = (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_FETCH;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            wait_cnt <= '0;
         else if (state_q == ST_FETCH || state_q == ST_MEM)
            wait_cnt <= wait_cnt + CW'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      pc_src     = PC_PLUS4;
      RegWrite   = 1'b0;
      MemToReg   = 1'b0;
      ALUSrc     = 1'b0;
      immControl = 1'b0;
      ALUControl = ALU_ADD;
      trap       = 1'b0;
      state      = 3'd0;
      // Outputs are forced low for the whole reset cycle, not only after the edge
      if (!reset) begin
         state = state_q;
         case (state_q)
            ST_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = ST_DECODE;
               end else if (wait_done) begin
                  state_d = ST_TRAP;
               end
            end
            ST_DECODE: state_d = dec_opcode_ok ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
               if (!dec_legal) begin
                  state_d = ST_TRAP;
               end else begin
                  ALUControl = dec_alu_control;
                  ALUSrc     = dec_alu_src;
                  immControl = dec_imm_control;
                  case (dec_iclass)
                     IC_LW, IC_SW: state_d = ST_MEM;
                     IC_BEQ: begin
                        pc_we   = 1'b1;
                        pc_src  = alu_zero ? PC_IMM : PC_PLUS4;
                        state_d = ST_FETCH;
                     end
                     default: state_d = ST_WB;
                  endcase
               end
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (dec_iclass == IC_SW);
               if (dmem_ready) begin
                  if (dec_iclass == IC_SW) begin
                     pc_we   = 1'b1;
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_WB;
                  end
               end else if (wait_done) begin
                  state_d = ST_TRAP;
               end
            end
            ST_WB: begin
               RegWrite = 1'b1;
               pc_we    = 1'b1;
               MemToReg = (dec_iclass == IC_LW);
               if (dec_iclass == IC_JAL)
                  pc_src = PC_IMM;
               else if (dec_iclass == IC_JALR)
                  pc_src = PC_ALU;
               state_d = ST_FETCH;
            end
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench against a per-instruction cycle-plan model
module tb_multicycle_ctrl;

   localparam int T = 15;

   typedef struct packed {
      logic [2:0] st;
      logic       imem_req, dmem_req, dmem_we, pc_we, ir_we;
      logic [1:0] pc_src;
      logic       regw, m2r, alusrc, immc;
      logic [2:0] aluc;
      logic       trap;
   } out_t;

   typedef struct packed {
      logic        rst, imem_rdy, dmem_rdy, z;
      logic [31:0] instr;
      out_t        o;
   } rec_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] instr = '0;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0;
   logic        imem_req, dmem_req, dmem_we, pc_we, ir_we;
   logic [1:0]  pc_src;
   logic        RegWrite, MemToReg, ALUSrc, immControl, trap;
   logic [2:0]  ALUControl, state;

   rec_t plan[$];
   out_t cmp_q[$];
   out_t d_out, e_out;
   int   checks = 0, failures = 0, cyc = 0, z_force = -1;

   multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .instr(instr),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .pc_we(pc_we), .ir_we(ir_we), .pc_src(pc_src),
      .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
      .immControl(immControl), .ALUControl(ALUControl),
      .trap(trap), .state(state)
   );

   always #5 clk = ~clk;

   task automatic pin(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // kind: 0 bad opcode, 1 bad R funct, 2 ALU+WB, 3 BEQ, 4 LW, 5 SW, 6 JAL, 7 JALR
   task automatic classify(input logic [31:0] w, output int kind,
                           output logic [2:0] ac, output logic as_, output logic ic);
      kind = 2; ac = 3'b000; as_ = 1'b0; ic = 1'b0;
      case (w[6:0])
         7'b0110011: begin
            if (w[31:25] == 7'd0 && w[14:12] == 3'b000) ac = 3'b000;
            else if (w[31:25] == 7'b0100000 && w[14:12] == 3'b000) ac = 3'b001;
            else if (w[31:25] == 7'd0 && w[14:12] == 3'b010) ac = 3'b100;
            else if (w[31:25] == 7'd0 && w[14:12] == 3'b111) ac = 3'b011;
            else kind = 1;
         end
         7'b0010011: begin as_ = 1'b1; ic = 1'b1; end
         7'b0001011: ac = 3'b010;
         7'b1100011: begin kind = 3; ac = 3'b001; ic = 1'b1; end
         7'b0000011: begin kind = 4; as_ = 1'b1; ic = 1'b1; end
         7'b0100011: begin kind = 5; as_ = 1'b1; ic = 1'b1; end
         7'b0110111: begin ac = 3'b101; as_ = 1'b1; ic = 1'b1; end
         7'b1101111: begin kind = 6; ic = 1'b1; end
         7'b1100111: begin kind = 7; as_ = 1'b1; ic = 1'b1; end
         default: kind = 0;
      endcase
   endtask

   function automatic rec_t fresh(input logic [31:0] w);
      rec_t r;
      r.rst      = 1'b0;
      r.imem_rdy = 1'($urandom);
      r.dmem_rdy = 1'($urandom);
      r.z        = (z_force < 0) ? 1'($urandom) : z_force[0];
      r.instr    = w;
      r.o        = '0;
      return r;
   endfunction

   task automatic add_reset(input int n);
      rec_t r;
      for (int i = 0; i < n; i++) begin
         r = fresh(32'h0);
         r.rst = 1'b1;
         plan.push_back(r);
      end
   endtask

   task automatic trap_tail(input logic [31:0] w);
      rec_t r;
      for (int i = 0; i < 3; i++) begin
         r = fresh(w);
         r.o.st = 3'd7;
         r.o.trap = 1'b1;
         plan.push_back(r);
      end
      add_reset(2);
   endtask

   // Appends the expected cycle-by-cycle life of one instruction given its handshake delays
   task automatic build(input logic [31:0] w, input int di, input int dd, input int abort_after);
      rec_t r;
      int kind;
      logic [2:0] ac;
      logic as_, ic;
      classify(w, kind, ac, as_, ic);
      for (int k = 0; k < ((di < T) ? di : T); k++) begin
         r = fresh(w); r.imem_rdy = 1'b0; r.o.imem_req = 1'b1; plan.push_back(r);
      end
      if (di >= T) begin trap_tail(w); return; end
      r = fresh(w); r.imem_rdy = 1'b1; r.o.imem_req = 1'b1; r.o.ir_we = 1'b1; plan.push_back(r);
      r = fresh(w); r.o.st = 3'd1; plan.push_back(r);
      if (kind == 0) begin trap_tail(w); return; end
      r = fresh(w); r.o.st = 3'd2;
      if (kind == 1) begin plan.push_back(r); trap_tail(w); return; end
      r.o.aluc = ac; r.o.alusrc = as_; r.o.immc = ic;
      if (kind == 3) begin
         r.o.pc_we = 1'b1; r.o.pc_src = {1'b0, r.z}; plan.push_back(r); return;
      end
      plan.push_back(r);
      if (kind == 4 || kind == 5) begin
         for (int k = 0; k < ((dd < T) ? dd : T); k++) begin
            if (k == abort_after) begin add_reset(2); return; end
            r = fresh(w); r.o.st = 3'd3; r.dmem_rdy = 1'b0;
            r.o.dmem_req = 1'b1; r.o.dmem_we = (kind == 5); plan.push_back(r);
         end
         if (dd >= T) begin trap_tail(w); return; end
         r = fresh(w); r.o.st = 3'd3; r.dmem_rdy = 1'b1;
         r.o.dmem_req = 1'b1; r.o.dmem_we = (kind == 5);
         if (kind == 5) begin r.o.pc_we = 1'b1; plan.push_back(r); return; end
         plan.push_back(r);
      end
      r = fresh(w); r.o.st = 3'd4; r.o.regw = 1'b1; r.o.pc_we = 1'b1;
      r.o.m2r = (kind == 4);
      r.o.pc_src = (kind == 6) ? 2'b01 : (kind == 7) ? 2'b10 : 2'b00;
      plan.push_back(r);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 12))
         0:  begin w[6:0] = 7'b0110011; w[31:25] = 7'b0000000; w[14:12] = 3'b000; end
         1:  begin w[6:0] = 7'b0110011; w[31:25] = 7'b0100000; w[14:12] = 3'b000; end
         2:  begin w[6:0] = 7'b0110011; w[31:25] = 7'b0000000; w[14:12] = 3'b010; end
         3:  begin w[6:0] = 7'b0110011; w[31:25] = 7'b0000000; w[14:12] = 3'b111; end
         4:  w[6:0] = 7'b0010011;
         5:  w[6:0] = 7'b0001011;
         6:  w[6:0] = 7'b1100011;
         7:  w[6:0] = 7'b0000011;
         8:  w[6:0] = 7'b0100011;
         9:  w[6:0] = 7'b0110111;
         10: w[6:0] = 7'b1101111;
         11: w[6:0] = 7'b1100111;
         default: begin
            if ($urandom_range(0, 1) == 0) w[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b1111111;
            else begin w[6:0] = 7'b0110011; w[14:12] = 3'b001; end
         end
      endcase
      return w;
   endfunction

   function automatic int rand_wait();
      return ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 3));
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (cmp_q.size() > 0) begin
         e_out = cmp_q.pop_front();
         d_out = {state, imem_req, dmem_req, dmem_we, pc_we, ir_we, pc_src,
                  RegWrite, MemToReg, ALUSrc, immControl, ALUControl, trap};
         checks++;
         if (d_out !== e_out) begin
            failures++;
            $display("FAIL outputs cycle=%0d actual=%h required=%h", cyc, d_out, e_out);
         end
      end
   end

   initial begin
      int b, cnt, cnt2, idx;
      add_reset(2);

      b = plan.size();
      build(32'h00500093, 1, 0, -1);
      pin("addi_len", plan.size() - b, 5);
      pin("addi_irwe_c1", int'(plan[b+1].o.ir_we), 1);
      pin("addi_exec_alu", int'({plan[b+3].o.aluc, plan[b+3].o.alusrc}), 1);
      pin("addi_wb_c4", int'({plan[b+4].o.regw, plan[b+4].o.pc_we, plan[b+4].o.pc_src}), 12);

      b = plan.size();
      build(32'h0000a103, 0, 3, -1);
      cnt = 0; cnt2 = 0;
      for (int i = b; i < plan.size(); i++) begin
         cnt  += int'(plan[i].o.dmem_req);
         cnt2 += int'(plan[i].o.dmem_we);
      end
      pin("lw_req_cycles", cnt, 4);
      pin("lw_we_cycles", cnt2, 0);
      pin("lw_wb", int'({plan[plan.size()-1].o.m2r, plan[plan.size()-1].o.regw}), 3);

      for (int zz = 1; zz >= 0; zz--) begin
         z_force = zz;
         b = plan.size();
         build(32'h00208463, 0, 0, -1);
         cnt = 0;
         for (int i = b; i < plan.size(); i++) cnt += int'(plan[i].o.regw);
         pin("beq_pc", int'({plan[b+2].o.pc_we, plan[b+2].o.pc_src}), (zz == 1) ? 5 : 4);
         pin("beq_no_regwrite", cnt, 0);
      end
      z_force = -1;

      b = plan.size();
      build(32'h00500093, 20, 0, -1);
      idx = -1;
      for (int i = plan.size() - 1; i >= b; i--) if (plan[i].o.trap) idx = i;
      pin("fetch_timeout_idx", idx - b, 15);

      b = plan.size();
      build(32'h00500093, 14, 0, -1);
      pin("fetch_ready_on_last", int'(plan[b+14].o.ir_we), 1);

      b = plan.size();
      build(32'h00000000, 0, 0, -1);
      pin("op0_trap", int'(plan[b+2].o.trap), 1);

      b = plan.size();
      build(32'h0020a023, 0, 5, 2);
      cnt = 0;
      for (int i = b; i < plan.size(); i++) cnt += int'(plan[i].o.pc_we);
      pin("sw_abort_no_pcwe", cnt, 0);
      pin("sw_abort_reset", int'({plan[b+4].o.dmem_we, plan[b+5].rst}), 3);
      build(32'h00500093, 0, 0, -1);
      pin("sw_abort_restart", int'({plan[b+7].o.st, plan[b+7].o.imem_req}), 1);

      build(32'h0000a103, 1, 14, -1);
      build(32'h0020a023, 2, 15, -1);

      for (int n = 0; n < 150; n++)
         build(rand_instr(), rand_wait(), rand_wait(),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1);

      foreach (plan[i]) begin
         @(posedge clk);
         #1;
         reset      = plan[i].rst;
         imem_ready = plan[i].imem_rdy;
         dmem_ready = plan[i].dmem_rdy;
         alu_zero   = plan[i].z;
         instr      = plan[i].instr;
         cmp_q.push_back(plan[i].o);
      end
      @(negedge clk);
      #1;
      pin("compare_drained", cmp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
